downsample_hls_deadlock_detector: RTL

- Consumes the per-instance `block` outputs of the downsample HLS deadlock monitors and decides when a stall is a real deadlock.
- Filters transient blocks: a monitor's block must persist for THRESHOLD consecutive cycles.
- On a confirmed deadlock, latches a sticky flag, the offending monitor index, a snapshot of all block inputs and a cycle timestamp, for debug readout / ILA trigger.
- Sits directly downstream of the monitors, at the top of the colorspace/downsample IP debug path.

---
 rtl/downsample_hls_deadlock_detector.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/downsample_hls_deadlock_detector.sv
// Deadlock detector for the downsample HLS monitors: filters transient blocks
// and latches a sticky debug capture once any monitor stays blocked for THRESHOLD cycles.
module downsample_hls_deadlock_detector #(
    parameter int NUM_MON   = 2,
    parameter int THRESHOLD = 1024,
    parameter int TS_W      = 32,
    localparam int IDX_W    = (NUM_MON > 1) ? $clog2(NUM_MON) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               clear,
    input  logic [NUM_MON-1:0] block_in,
    output logic               deadlock,
    output logic               deadlock_pulse,
    output logic [IDX_W-1:0]   deadlock_idx,
    output logic [NUM_MON-1:0] deadlock_mask,
    output logic [TS_W-1:0]    deadlock_cycle
);

    localparam int CNT_W = $clog2(THRESHOLD + 1);
    localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(THRESHOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(THRESHOLD);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WATCH  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [CNT_W-1:0]     cnt_q [NUM_MON];
    logic [CNT_W-1:0]     cnt_d [NUM_MON];
    logic [NUM_MON-1:0]   hit;
    logic                 lock;
    logic                 cnt_run;
    logic [IDX_W-1:0]     lock_idx;
    logic [TS_W-1:0]      ts_q;

    always_comb begin
        state_d  = state_q;
        lock     = 1'b0;
        lock_idx = '0;
        hit      = '0;
        cnt_run  = 1'b0;

        for (int i = 0; i < NUM_MON; i++) begin
            hit[i] = (state_q == WATCH) && block_in[i] && (cnt_q[i] == CNT_HIT);
        end
        // Descending scan so the lowest hitting index is the one that sticks.
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (hit[i]) begin
                lock_idx = IDX_W'(i);
            end
        end

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = WATCH;
                end
            end
            WATCH: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if ((|hit) && !clear) begin
                    state_d = LOCKED;
                    lock    = 1'b1;
                end
            end
            LOCKED: begin
                if (clear) begin
                    state_d = enable ? WATCH : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Runs only accumulate while watching continues uninterrupted; any
        // clear, lock or exit starts the next run from zero.
        cnt_run = (state_q == WATCH) && (state_d == WATCH) && !clear;
        for (int i = 0; i < NUM_MON; i++) begin
            if (!cnt_run || !block_in[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                cnt_d[i] = cnt_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            for (int i = 0; i < NUM_MON; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            for (int i = 0; i < NUM_MON; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ts_q <= '0;
        end else if (enable && (ts_q != {TS_W{1'b1}})) begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    // Capture registers: loaded on the lock edge, zeroed only by clear in LOCKED.
    always_ff @(posedge clock) begin
        if (reset) begin
            deadlock       <= 1'b0;
            deadlock_pulse <= 1'b0;
            deadlock_idx   <= '0;
            deadlock_mask  <= '0;
            deadlock_cycle <= '0;
        end else begin
            deadlock_pulse <= lock;
            if (lock) begin
                deadlock       <= 1'b1;
                deadlock_idx   <= lock_idx;
                deadlock_mask  <= block_in;
                deadlock_cycle <= ts_q;
            end else if ((state_q == LOCKED) && clear) begin
                deadlock       <= 1'b0;
                deadlock_idx   <= '0;
                deadlock_mask  <= '0;
                deadlock_cycle <= '0;
            end
        end
    end

endmodule
